regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources: ALU and LSU.

---
 rtl/regfile_wb_arbiter_if.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: ALU/LSU write handshakes, regfile write port and hazard lookup.
// The fwd_data_a/fwd_data_b members exist only when REGFILE_WB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              hit_a;
  logic              hit_b;
`ifdef REGFILE_WB_FWD_EN
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
`endif

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output rd_addr_a, rd_addr_b,
    input  alu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  hit_a, hit_b
`ifdef REGFILE_WB_FWD_EN
    , input fwd_data_a, fwd_data_b
`endif
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  rd_addr_a, rd_addr_b,
    output alu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output hit_a, hit_b
`ifdef REGFILE_WB_FWD_EN
    , output fwd_data_a, fwd_data_b
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source (ALU/LSU) oldest-first writeback arbiter feeding a registered regfile write stage,
// with RAW hazard lookup. REGFILE_WB_FWD_EN adds youngest-pending-write forwarding data.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_arbiter_if.slave    bus
);

  logic              alu_v_r;
  logic [ADDR_W-1:0] alu_addr_r;
  logic [DATA_W-1:0] alu_data_r;
  logic              lsu_v_r;
  logic [ADDR_W-1:0] lsu_addr_r;
  logic [DATA_W-1:0] lsu_data_r;
  logic              age_r;
  logic              rdy_en_r;
  logic              rf_wen_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;

  logic alu_gnt_s, lsu_gnt_s;
  logic alu_rdy_s, lsu_rdy_s;
  logic alu_take_s, lsu_take_s;
  logic alu_keep_s, lsu_keep_s;
  logic age_nxt_s;
  logic hit_a_s, hit_b_s;

  function automatic logic hit_f(input logic [ADDR_W-1:0] rd);
    logic match;
    match = (alu_v_r && (alu_addr_r == rd)) ||
            (lsu_v_r && (lsu_addr_r == rd)) ||
            (rf_wen_r && (rf_waddr_r == rd));
    hit_f = (rd != {ADDR_W{1'b0}}) && match;
  endfunction

  // Oldest-first grant, ready, capture qualification and next age
  always_comb begin
    alu_gnt_s  = alu_v_r && (!lsu_v_r || age_r);
    lsu_gnt_s  = lsu_v_r && (!alu_v_r || !age_r);
    alu_rdy_s  = rdy_en_r && (!alu_v_r || alu_gnt_s);
    lsu_rdy_s  = rdy_en_r && (!lsu_v_r || lsu_gnt_s);
    // x0 writes complete the handshake but are never stored
    alu_take_s = bus.alu_valid && alu_rdy_s && (bus.alu_addr != {ADDR_W{1'b0}});
    lsu_take_s = bus.lsu_valid && lsu_rdy_s && (bus.lsu_addr != {ADDR_W{1'b0}});
    alu_keep_s = alu_v_r && !alu_gnt_s;
    lsu_keep_s = lsu_v_r && !lsu_gnt_s;
    age_nxt_s  = age_r;
    if (alu_take_s && lsu_take_s) begin
      age_nxt_s = 1'b1;
    end else if (alu_take_s) begin
      age_nxt_s = !lsu_keep_s;
    end else if (lsu_take_s) begin
      age_nxt_s = alu_keep_s;
    end else begin
      age_nxt_s = age_r;
    end
  end

  // Holding registers, age bit and the registered regfile write stage
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_v_r    <= 1'b0;
      alu_addr_r <= {ADDR_W{1'b0}};
      alu_data_r <= {DATA_W{1'b0}};
      lsu_v_r    <= 1'b0;
      lsu_addr_r <= {ADDR_W{1'b0}};
      lsu_data_r <= {DATA_W{1'b0}};
      age_r      <= 1'b0;
      rdy_en_r   <= 1'b0;
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else begin
      rdy_en_r <= 1'b1;
      age_r    <= age_nxt_s;
      if (alu_take_s) begin
        alu_v_r    <= 1'b1;
        alu_addr_r <= bus.alu_addr;
        alu_data_r <= bus.alu_data;
      end else if (alu_gnt_s) begin
        alu_v_r <= 1'b0;
      end
      if (lsu_take_s) begin
        lsu_v_r    <= 1'b1;
        lsu_addr_r <= bus.lsu_addr;
        lsu_data_r <= bus.lsu_data;
      end else if (lsu_gnt_s) begin
        lsu_v_r <= 1'b0;
      end
      if (alu_gnt_s) begin
        rf_wen_r   <= 1'b1;
        rf_waddr_r <= alu_addr_r;
        rf_wdata_r <= alu_data_r;
      end else if (lsu_gnt_s) begin
        rf_wen_r   <= 1'b1;
        rf_waddr_r <= lsu_addr_r;
        rf_wdata_r <= lsu_data_r;
      end else begin
        rf_wen_r <= 1'b0;
      end
    end
  end

  // RAW hazard lookup against both holding entries and the write stage
  always_comb begin
    hit_a_s = hit_f(bus.rd_addr_a);
    hit_b_s = hit_f(bus.rd_addr_b);
  end

  assign bus.alu_ready = alu_rdy_s;
  assign bus.lsu_ready = lsu_rdy_s;
  assign bus.rf_wen    = rf_wen_r;
  assign bus.rf_waddr  = rf_waddr_r;
  assign bus.rf_wdata  = rf_wdata_r;
  assign bus.hit_a     = hit_a_s;
  assign bus.hit_b     = hit_b_s;

`ifdef REGFILE_WB_FWD_EN
  logic [DATA_W-1:0] fwd_a_s, fwd_b_s;

  // Youngest match wins: younger hold, then older hold, then the write stage
  function automatic logic [DATA_W-1:0] fwd_f(input logic [ADDR_W-1:0] rd);
    logic am, lm;
    am = alu_v_r && (alu_addr_r == rd);
    lm = lsu_v_r && (lsu_addr_r == rd);
    if (rd == {ADDR_W{1'b0}}) begin
      fwd_f = {DATA_W{1'b0}};
    end else if (am && lm) begin
      fwd_f = age_r ? lsu_data_r : alu_data_r;
    end else if (am) begin
      fwd_f = alu_data_r;
    end else if (lm) begin
      fwd_f = lsu_data_r;
    end else if (rf_wen_r && (rf_waddr_r == rd)) begin
      fwd_f = rf_wdata_r;
    end else begin
      fwd_f = {DATA_W{1'b0}};
    end
  endfunction

  // Forwarding data for both read ports
  always_comb begin
    fwd_a_s = fwd_f(bus.rd_addr_a);
    fwd_b_s = fwd_f(bus.rd_addr_b);
  end

  assign bus.fwd_data_a = fwd_a_s;
  assign bus.fwd_data_b = fwd_b_s;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: an age-ordered queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Pending writes, oldest at the front; at most one per source
  typedef struct packed {
    logic          src;   // 0 = ALU, 1 = LSU
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;
  ent_t          q[$];
  logic          m_en    = 1'b0;
  logic          m_wen   = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  logic          s_rst, s_av, s_lv;
  logic [AW-1:0] s_aa, s_la, s_ra, s_rb;
  logic [DW-1:0] s_ad, s_ld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic exp_ready(input logic s);
    logic has;
    has = 1'b0;
    foreach (q[i]) if (q[i].src == s) has = 1'b1;
    if (!m_en) return 1'b0;
    if (!has) return 1'b1;
    return q[0].src == s;
  endfunction

  function automatic logic exp_hit(input logic [AW-1:0] rd);
    logic m;
    m = m_wen && (m_waddr == rd);
    foreach (q[i]) if (q[i].addr == rd) m = 1'b1;
    return (rd != 5'd0) && m;
  endfunction

  function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] rd);
    if (!exp_hit(rd)) return 32'd0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].addr == rd) return q[i].data;
    return m_wdata;
  endfunction

  task automatic model_step();
    logic a_acc, l_acc;
    ent_t e;
    if (rst) begin
      q.delete();
      m_en = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      a_acc = bus.alu_valid && exp_ready(1'b0) && (bus.alu_addr != 5'd0);
      l_acc = bus.lsu_valid && exp_ready(1'b1) && (bus.lsu_addr != 5'd0);
      m_en = 1'b1;
      if (q.size() > 0) begin
        e = q.pop_front();
        m_wen = 1'b1; m_waddr = e.addr; m_wdata = e.data;
      end else begin
        m_wen = 1'b0;
      end
      if (a_acc) begin e.src = 1'b0; e.addr = bus.alu_addr; e.data = bus.alu_data; q.push_back(e); end
      if (l_acc) begin e.src = 1'b1; e.addr = bus.lsu_addr; e.data = bus.lsu_data; q.push_back(e); end
    end
  endtask

  task automatic compare_all();
    chk("rf_wen", 32'(bus.rf_wen), 32'(m_wen));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
    chk("rf_wdata", bus.rf_wdata, m_wdata);
    chk("alu_ready", 32'(bus.alu_ready), 32'(exp_ready(1'b0)));
    chk("lsu_ready", 32'(bus.lsu_ready), 32'(exp_ready(1'b1)));
    chk("hit_a", 32'(bus.hit_a), 32'(exp_hit(bus.rd_addr_a)));
    chk("hit_b", 32'(bus.hit_b), 32'(exp_hit(bus.rd_addr_b)));
`ifdef REGFILE_WB_FWD_EN
    chk("fwd_a", bus.fwd_data_a, exp_fwd(bus.rd_addr_a));
    chk("fwd_b", bus.fwd_data_b, exp_fwd(bus.rd_addr_b));
`endif
  endtask

  // One clock: model advances on the edge, staged inputs applied, then everything compared
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    rst           = s_rst;
    bus.alu_valid = s_av; bus.alu_addr = s_aa; bus.alu_data = s_ad;
    bus.lsu_valid = s_lv; bus.lsu_addr = s_la; bus.lsu_data = s_ld;
    bus.rd_addr_a = s_ra; bus.rd_addr_b = s_rb;
    #1;
    compare_all();
  endtask

  task automatic idle();
    s_rst = 1'b0; s_av = 1'b0; s_lv = 1'b0;
    s_aa = '0; s_la = '0; s_ad = '0; s_ld = '0;
  endtask

  initial begin
    int cnt, gaps;
    logic started, ended;
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_data = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    idle(); s_rst = 1'b1; s_ra = '0; s_rb = '0;

    // Reset for two cycles, then release
    step(); step();
    chk("rst_wen", 32'(bus.rf_wen), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    s_rst = 1'b0; step(); step();
    chk("rst_alu_rdy", 32'(bus.alu_ready), 32'd1);
    chk("rst_lsu_rdy", 32'(bus.lsu_ready), 32'd1);

    // ALU x5 = 0x11: written two edges after acceptance
    s_av = 1'b1; s_aa = 5'd5; s_ad = 32'h11; step();
    idle(); step();
    chk("lat_not_early", 32'(bus.rf_wen), 32'd0);
    step();
    chk("lat_wen", 32'(bus.rf_wen), 32'd1);
    chk("lat_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("lat_wdata", bus.rf_wdata, 32'h11);
    step();

    // Same edge, same address: ALU first, hazard held through both writes
    s_av = 1'b1; s_aa = 5'd3; s_ad = 32'hA; s_lv = 1'b1; s_la = 5'd3; s_ld = 32'hB; s_ra = 5'd3;
    step(); idle(); step();
    chk("dup_hit0", 32'(bus.hit_a), 32'd1);
    step();
    chk("dup_w1_addr", 32'(bus.rf_waddr), 32'd3);
    chk("dup_w1_data", bus.rf_wdata, 32'hA);
    chk("dup_hit1", 32'(bus.hit_a), 32'd1);
    step();
    chk("dup_w2_data", bus.rf_wdata, 32'hB);
    chk("dup_hit2", 32'(bus.hit_a), 32'd1);
    step();
    chk("dup_done_wen", 32'(bus.rf_wen), 32'd0);
    chk("dup_done_hit", 32'(bus.hit_a), 32'd0);

    // LSU x7 first, ALU x8 the next edge
    s_lv = 1'b1; s_la = 5'd7; s_ld = 32'h77; s_ra = 5'd7; step();
    idle(); s_av = 1'b1; s_aa = 5'd8; s_ad = 32'h88; step();
    chk("ord_hit7", 32'(bus.hit_a), 32'd1);
`ifdef REGFILE_WB_FWD_EN
    chk("ord_fwd7", bus.fwd_data_a, 32'h77);
`endif
    idle(); step();
    chk("ord_first", 32'(bus.rf_waddr), 32'd7);
    step();
    chk("ord_second", 32'(bus.rf_waddr), 32'd8);
    step();

    // Age flip: both captured (ALU older), ALU refilled while LSU waits -> x9, x7, x8
    s_av = 1'b1; s_aa = 5'd9; s_ad = 32'h99; s_lv = 1'b1; s_la = 5'd7; s_ld = 32'h70; step();
    s_lv = 1'b0; s_aa = 5'd8; s_ad = 32'h80; step();
    idle(); step();
    chk("age_w1", 32'(bus.rf_waddr), 32'd9);
    step();
    chk("age_w2", 32'(bus.rf_waddr), 32'd7);
    chk("age_w2_data", bus.rf_wdata, 32'h70);
    step();
    chk("age_w3", 32'(bus.rf_waddr), 32'd8);
    step();

    // Write to x0 is accepted and dropped
    s_av = 1'b1; s_aa = 5'd0; s_ad = 32'hFF; s_ra = 5'd0; step();
    chk("x0_ready", 32'(bus.alu_ready), 32'd1);
    idle(); step();
    chk("x0_hit", 32'(bus.hit_a), 32'd0);
    step();
    chk("x0_no_wen", 32'(bus.rf_wen), 32'd0);

    // ALU burst x1..x10 with LSU idle
    cnt = 0; gaps = 0; started = 1'b0; ended = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      if (i <= 10) begin
        s_av = 1'b1; s_aa = 5'(i); s_ad = 32'h100 + 32'(i);
      end else begin
        idle();
      end
      step();
      if (i <= 10) chk("burst_rdy", 32'(bus.alu_ready), 32'd1);
      if (bus.rf_wen) begin
        cnt++;
        if (ended) gaps++;
        started = 1'b1;
        chk("burst_addr", 32'(bus.rf_waddr), 32'(cnt));
      end else if (started) begin
        ended = 1'b1;
      end
    end
    chk("burst_count", 32'(cnt), 32'd10);
    chk("burst_gaps", 32'(gaps), 32'd0);

    // Reset with both entries pending discards them
    s_av = 1'b1; s_aa = 5'd12; s_ad = 32'hC; s_lv = 1'b1; s_la = 5'd13; s_ld = 32'hD;
    s_ra = 5'd12; s_rb = 5'd13; step();
    idle(); s_rst = 1'b1; step();
    chk("mid_hit_a", 32'(bus.hit_a), 32'd1);
    chk("mid_hit_b", 32'(bus.hit_b), 32'd1);
    s_rst = 1'b0; step();
    chk("mid_wen", 32'(bus.rf_wen), 32'd0);
    chk("mid_hit_a_clr", 32'(bus.hit_a), 32'd0);
    chk("mid_hit_b_clr", 32'(bus.hit_b), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_write", 32'(bus.rf_wen), 32'd0);
    end

    // Randomized traffic with dense address reuse and occasional reset
    for (int i = 0; i < 4000; i++) begin
      s_rst = ($urandom_range(0, 199) == 0);
      s_av  = ($urandom_range(0, 99) < 60);
      s_lv  = ($urandom_range(0, 99) < 50);
      s_aa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s_la  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s_ad  = $urandom;
      s_ld  = $urandom;
      s_ra  = 5'($urandom_range(0, 7));
      s_rb  = 5'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
